pc_gen: RTL
===========

Name: pc_gen

Overview:
- Registered program-counter generator for the MIPS datapath.
- Replaces the combinational extender/branch-address path with a parametrised block that owns the PC register and performs immediate extension (sign/zero/LUI).
- Computes branch, jump and jump-register targets, and takes interrupt and exception vectors.
- Honours the PC[31] supervisor bit and supports pipeline stall, with a latched pending interrupt.

Parameters:
- IMM_W, 16: immediate width; legal 8..16.
- RESET_VEC, 32'h8000_0000: PC value loaded on reset.
- ILLOP_VEC, 32'h8000_0004: interrupt entry vector.
- XADR_VEC, 32'h8000_0008: exception entry vector.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- stall, input, 1: 1 = hold PC and suppress all state updates.
- pc_src, input, 3: 0 = PC+4, 1 = branch, 2 = jump, 3 = jr, 4 = exception; 5–7 are treated as 0.
- branch_cond, input, 1: branch taken, qualifies pc_src = 1.
- imm, input, IMM_W: instruction immediate.
- ext_op, input, 1: 1 = sign-extend, 0 = zero-extend.
- lu_op, input, 1: 1 = place imm in the upper bits.
- jump_target, input, 26: J/JAL target field.
- jr_addr, input, 32: register value for JR/JALR.
- irq, input, 1: level interrupt request.
- pc, output, 32: current PC (registered).
- pc_plus4, output, 32: {pc[31], pc[30:0]+4}, combinational.
- ext_out, output, 32: extended immediate, combinational.
- con_ba, output, 32: branch target, combinational.
- epc, output, 32: saved return address (registered).
- epc_we, output, 1: one-cycle pulse when epc is written.
- irq_pending, output, 1: latched interrupt not yet taken (registered).

Behaviour:
- Reset (async, low):
  - pc = RESET_VEC, epc = 0, epc_we = 0, irq_pending = 0.
  - Takes effect immediately, mid-stall or otherwise.
  - First fetch after release is RESET_VEC.
- Extension:
  - ext = ext_op ? sign-extend(imm) : zero-extend(imm) to 32 bits.
  - ext_out = lu_op ? {imm, (32-IMM_W) zeros} : ext.
- pc_plus4 arithmetic:
  - pc[30:0]+4 wraps modulo 2^31.
  - Bit 31 is never altered by the increment.
- con_ba:
  - bits [30:0] = (pc_plus4[30:0] + (ext<<2)[30:0]) mod 2^31.
  - bit 31 = pc[31].
  - ext here is the sign/zero-extended value, never the lu_op form.
- Jump target: {pc_plus4[31:28], jump_target, 2'b00}.
- jr target:
  - Supervisor mode (pc[31] = 1): jr_addr as-is, so JR may leave supervisor mode.
  - User mode (pc[31] = 0): {1'b0, jr_addr[30:0]}, so user code cannot enter supervisor mode via JR.
- Interrupt eligibility: take_irq = (irq | irq_pending) & ~pc[31].
- Next-PC priority, evaluated each non-stalled cycle:
  1. pc_src = 4: pc <= XADR_VEC, epc <= pc_plus4, epc_we = 1.
  2. take_irq: pc <= ILLOP_VEC, epc <= pc_plus4, epc_we = 1, irq_pending <= 0.
  3. pc_src = 1 with branch_cond: pc <= con_ba.
  4. pc_src = 1 without branch_cond: pc <= pc_plus4.
  5. pc_src = 2: pc <= jump target.
  6. pc_src = 3: pc <= jr target.
  7. otherwise: pc <= pc_plus4.
- Exception beats interrupt in the same cycle:
  - An eligible irq in that cycle sets irq_pending <= 1.
  - That interrupt is taken only after supervisor mode is left.
- epc_we is a registered pulse:
  - High exactly the cycle after a vector is taken.
  - Low on every other cycle, including all stalled cycles.
- Stall:
  - pc, epc and epc_we (forced 0) hold.
  - irq = 1 during stall sets irq_pending <= 1 regardless of mode.
  - irq_pending persists until taken; it is not cleared by irq dropping.
- Supervisor masking:
  - While pc[31] = 1, irq and irq_pending are never taken.
  - irq_pending remains set; it is taken on the first non-stalled cycle with pc[31] = 0.
- Latency:
  - pc updates one clock after the select inputs are sampled.
  - ext_out, con_ba and pc_plus4 have zero latency.

Test Plan:
- Reset release, pc_src = 0, irq = 0, 3 clocks -> pc = 8000_0000, 8000_0004, 8000_0008, 8000_000C; epc = 0.
- Extension at pc = 0000_1000:
  - imm = FFFC, ext_op = 1, lu_op = 0 -> ext_out = FFFF_FFFC, con_ba = 0000_0FF4.
  - ext_op = 0 -> ext_out = 0000_FFFC.
  - lu_op = 1 -> ext_out = FFFC_0000.
- Branch and JR at pc = 0000_1000:
  - pc_src = 1, branch_cond = 1, imm = 0004 -> pc = 0000_1014.
  - branch_cond = 0 -> pc = 0000_1004.
  - pc_src = 3, jr_addr = 8000_0040 -> pc = 0000_0040 (bit 31 masked).
- Jump at pc = 1000_0000: pc_src = 2, jump_target = 3FF_FFFF -> pc = 1FFF_FFFC.
- Interrupt at pc = 0000_2000:
  - irq pulsed during 2-cycle stall, then stall = 0 -> pc = 8000_0004, epc = 0000_2004, epc_we high 1 cycle, irq_pending clears.
  - A further irq while pc = 8000_xxxx stays pending until jr to 0000_3000, then vectors from 0000_3000 with epc = 0000_3004.
- Exception and interrupt together at pc = 0000_2000: pc_src = 4 and irq = 1 -> pc = 8000_0008, epc = 0000_2004, irq_pending = 1.
- Reset mid-stall: reset asserted mid-stall with irq_pending = 1 -> all registers cleared asynchronously, pc = 8000_0000.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered MIPS program-counter generator with vectors and stall
//
// Owns the PC register. Also extends the immediate, forms the branch, jump and
// jump-register targets, and takes the interrupt and exception vectors.
// PC[31] is the supervisor bit.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stall        1 = hold pc/epc, force epc_we low, only latch irq
//   pc_src       0 seq, 1 branch, 2 jump, 3 jr, 4 exception (5..7 = seq)
//   branch_cond  branch taken qualifier for pc_src = 1
//   imm          instruction immediate (IMM_W bits)
//   ext_op       1 = sign-extend, 0 = zero-extend
//   lu_op        1 = immediate placed in the upper bits of ext_out
//   jump_target  J/JAL 26-bit target field
//   jr_addr      register operand for JR/JALR
//   irq          level interrupt request
//   pc           current PC (registered)
//   pc_plus4     {pc[31], pc[30:0]+4} (combinational)
//   ext_out      extended immediate (combinational)
//   con_ba       branch target (combinational)
//   epc          saved return address (registered)
//   epc_we       one-cycle pulse after epc is written
//   irq_pending  latched interrupt not yet taken (registered)

module pc_gen #(
  parameter int          IMM_W     = 16,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       pc_src,
  input  logic             branch_cond,
  input  logic [IMM_W-1:0] imm,
  input  logic             ext_op,
  input  logic             lu_op,
  input  logic [25:0]      jump_target,
  input  logic [31:0]      jr_addr,
  input  logic             irq,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      ext_out,
  output logic [31:0]      con_ba,
  output logic [31:0]      epc,
  output logic             epc_we,
  output logic             irq_pending
);

  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_EXC = 3'd4
  } pc_src_e;

  logic [31:0] ext;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;
  logic        take_irq;

  logic [31:0] pc_nxt;
  logic [31:0] epc_nxt;
  logic        epc_we_nxt;
  logic        irq_pending_nxt;

  // Immediate extension. The branch offset always uses the sign/zero form;
  // the LUI form only appears on ext_out.
  assign ext     = ext_op ? {{(32-IMM_W){imm[IMM_W-1]}}, imm}
                          : {{(32-IMM_W){1'b0}}, imm};
  assign ext_out = lu_op ? {imm, {(32-IMM_W){1'b0}}} : ext;

  // The increment and branch add are 31 bits wide, so they wrap inside the
  // current mode and can never flip the supervisor bit.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};
  assign con_ba   = {pc[31], pc_plus4[30:0] + {ext[28:0], 2'b00}};

  assign jmp_tgt = {pc_plus4[31:28], jump_target, 2'b00};

  // User code may not enter supervisor mode through JR. Supervisor code may
  // leave it.
  assign jr_tgt = pc[31] ? jr_addr : {1'b0, jr_addr[30:0]};

  assign take_irq = (irq | irq_pending) & ~pc[31];

  always_comb begin
    pc_nxt          = pc;
    epc_nxt         = epc;
    epc_we_nxt      = 1'b0;
    // An irq that is not taken this cycle is remembered. This covers stalls,
    // supervisor mode, and losing to an exception.
    irq_pending_nxt = irq_pending | irq;

    if (!stall) begin
      if (pc_src == SRC_EXC) begin
        pc_nxt     = XADR_VEC;
        epc_nxt    = pc_plus4;
        epc_we_nxt = 1'b1;
      end else if (take_irq) begin
        pc_nxt          = ILLOP_VEC;
        epc_nxt         = pc_plus4;
        epc_we_nxt      = 1'b1;
        irq_pending_nxt = 1'b0;
      end else begin
        case (pc_src)
          SRC_BR:  pc_nxt = branch_cond ? con_ba : pc_plus4;
          SRC_J:   pc_nxt = jmp_tgt;
          SRC_JR:  pc_nxt = jr_tgt;
          default: pc_nxt = pc_plus4;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_VEC;
      epc         <= 32'h0;
      epc_we      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      epc         <= epc_nxt;
      epc_we      <= epc_we_nxt;
      irq_pending <= irq_pending_nxt;
    end
  end

endmodule
